seven_seg_mux_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits sharing one segment bus.

---
 rtl/seven_seg_pkg.sv | 19 +
 rtl/seven_seg_hex_decode.sv | 13 +
 rtl/seven_seg_mux_driver.sv | 158 +++++++++++++++
 tb/tb_seven_seg_mux_driver.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed 7-segment driver.
// Segment patterns are active-high, bit 0 = a .. bit 6 = g.
package seven_seg_pkg;

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF_AH = 7'h00;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble-to-segment decoder; output is active-high, polarity is applied by the parent.
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Round-robin multiplexed 7-segment driver with dead time between digits,
// per-digit blanking and a double-buffered display frame committed on frame wrap.
module seven_seg_mux_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int ON_CYCLES      = 50000,
    parameter int DEAD_CYCLES    = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    load_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int CNT_MAX = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_OFF_AH : SEG_OFF_AH;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

    scan_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [IDX_W-1:0] idx, idx_next;

    logic [4*NUM_DIGITS-1:0] shadow_digits, disp_digits;
    logic [NUM_DIGITS-1:0]   shadow_blank, disp_blank;
    logic                    pending;
    logic                    commit;

    logic [3:0]            cur_nibble;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] cur_onehot;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    // Commit happens only on the slot-ending edge of the last digit.
    assign commit = (state == ON) && (cnt == ON_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DEAD;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        idx_next   = idx;
        case (state)
            DEAD: begin
                if (cnt == DEAD_LAST) begin
                    state_next = ON;
                    cnt_next   = '0;
                end
            end
            ON: begin
                if (cnt == ON_LAST) begin
                    state_next = DEAD;
                    cnt_next   = '0;
                    idx_next   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
            end
            default: begin
                state_next = DEAD;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_digits <= '0;
            shadow_blank  <= '0;
            disp_digits   <= '0;
            disp_blank    <= '0;
            pending       <= 1'b0;
        end else begin
            if (load_i) begin
                shadow_digits <= digits_i;
                shadow_blank  <= blank_i;
                pending       <= 1'b1;
            end
            // A load coinciding with the commit bypasses the shadow and leaves nothing pending.
            if (commit) begin
                pending <= 1'b0;
                if (load_i) begin
                    disp_digits <= digits_i;
                    disp_blank  <= blank_i;
                end else if (pending) begin
                    disp_digits <= shadow_digits;
                    disp_blank  <= shadow_blank;
                end
            end
        end
    end

    always_comb begin
        cur_nibble = '0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nibble    = disp_digits[4*k +: 4];
                cur_blank     = disp_blank[k];
                cur_onehot[k] = 1'b1;
            end
        end
    end

    seven_seg_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // idx and disp are stable across a DEAD->ON edge, so anode and segments always match.
    always_comb begin
        seg_next = SEG_OFF;
        an_next  = AN_OFF;
        if (state_next == ON) begin
            an_next = AN_ACTIVE_LOW ? ~cur_onehot : cur_onehot;
            if (!cur_blank) begin
                seg_next = SEG_ACTIVE_LOW ? ~dec_seg : dec_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_o   <= SEG_OFF;
            an_o    <= AN_OFF;
            frame_o <= 1'b0;
        end else begin
            seg_o   <= seg_next;
            an_o    <= an_next;
            frame_o <= commit;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Directed bench for seven_seg_mux_driver with 4 digits, 4-cycle ON slots and 2-cycle dead time.
module tb_seven_seg_mux_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int checks   = 0;
    int failures = 0;

    seven_seg_mux_driver #(
        .NUM_DIGITS     (4),
        .ON_CYCLES      (4),
        .DEAD_CYCLES    (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .digits_i (digits),
        .blank_i  (blank),
        .load_i   (load),
        .seg_o    (seg),
        .an_o     (an),
        .frame_o  (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One digit slot starting at its DEAD->ON edge: 4 lit cycles then 2 dead cycles.
    // ld_mode 1 loads during the lit slot, ld_mode 2 loads on the slot-ending edge.
    task automatic check_slot(input string tag, input logic [6:0] seg_exp, input logic [3:0] an_exp,
                              input bit last, input int ld_mode, input logic [15:0] ld_val,
                              input logic [3:0] ld_blank);
        for (int c = 0; c < 4; c++) begin
            if (ld_mode == 1 && c == 1) begin
                digits = ld_val;
                blank  = ld_blank;
                load   = 1'b1;
            end
            step();
            load = 1'b0;
            chk({tag, "_seg"}, 16'(seg), 16'(seg_exp));
            chk({tag, "_an"},  16'(an),  16'(an_exp));
        end
        for (int d = 0; d < 2; d++) begin
            if (ld_mode == 2 && d == 0) begin
                digits = ld_val;
                blank  = ld_blank;
                load   = 1'b1;
            end
            step();
            load = 1'b0;
            chk({tag, "_dead_seg"}, 16'(seg), 16'h007F);
            chk({tag, "_dead_an"},  16'(an),  16'h000F);
            chk({tag, "_frame"},    16'(frame), (d == 0 && last) ? 16'h1 : 16'h0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        digits = '0;
        blank  = '0;
        load   = 1'b0;
        repeat (3) step();
        chk("rst_seg",   16'(seg),   16'h007F);
        chk("rst_an",    16'(an),    16'h000F);
        chk("rst_frame", 16'(frame), 16'h0);

        // Release reset with a load of 3A10 on edge 1; frame 0 still shows the reset zeros.
        reset  = 1'b0;
        digits = 16'h3A10;
        load   = 1'b1;
        step();
        load = 1'b0;
        chk("e1_seg", 16'(seg), 16'h007F);
        chk("e1_an",  16'(an),  16'h000F);

        check_slot("f0_d0", 7'h40, 4'hE, 1'b0, 0, 16'h0, 4'h0);
        check_slot("f0_d1", 7'h40, 4'hD, 1'b0, 0, 16'h0, 4'h0);
        check_slot("f0_d2", 7'h40, 4'hB, 1'b0, 0, 16'h0, 4'h0);
        check_slot("f0_d3", 7'h40, 4'h7, 1'b1, 0, 16'h0, 4'h0);

        // Frame 1 shows 0,1,A,3; a mid-frame load of 4321 must not tear digits 1-3.
        check_slot("f1_d0", 7'h40, 4'hE, 1'b0, 0, 16'h0,    4'h0);
        check_slot("f1_d1", 7'h79, 4'hD, 1'b0, 1, 16'h4321, 4'h0);
        check_slot("f1_d2", 7'h08, 4'hB, 1'b0, 0, 16'h0,    4'h0);
        check_slot("f1_d3", 7'h30, 4'h7, 1'b1, 0, 16'h0,    4'h0);

        // Frame 2 shows 1,2,3,4; 7777 goes pending, then FFFF on the commit edge bypasses it.
        check_slot("f2_d0", 7'h79, 4'hE, 1'b0, 1, 16'h7777, 4'h0);
        check_slot("f2_d1", 7'h24, 4'hD, 1'b0, 0, 16'h0,    4'h0);
        check_slot("f2_d2", 7'h30, 4'hB, 1'b0, 0, 16'h0,    4'h0);
        check_slot("f2_d3", 7'h19, 4'h7, 1'b1, 2, 16'hFFFF, 4'h0);

        // Frame 3 shows F everywhere; load FFFF with digit 2 blanked.
        check_slot("f3_d0", 7'h0E, 4'hE, 1'b0, 0, 16'h0,    4'h0);
        check_slot("f3_d1", 7'h0E, 4'hD, 1'b0, 1, 16'hFFFF, 4'b0100);
        check_slot("f3_d2", 7'h0E, 4'hB, 1'b0, 0, 16'h0,    4'h0);
        check_slot("f3_d3", 7'h0E, 4'h7, 1'b1, 0, 16'h0,    4'h0);

        check_slot("f4_d0", 7'h0E, 4'hE, 1'b0, 0, 16'h0, 4'h0);
        check_slot("f4_d1", 7'h0E, 4'hD, 1'b0, 0, 16'h0, 4'h0);
        check_slot("f4_d2", 7'h7F, 4'hB, 1'b0, 0, 16'h0, 4'h0);
        check_slot("f4_d3", 7'h0E, 4'h7, 1'b1, 0, 16'h0, 4'h0);

        // Frame 5: reset lands two cycles into digit 3's lit slot.
        check_slot("f5_d0", 7'h0E, 4'hE, 1'b0, 0, 16'h0, 4'h0);
        check_slot("f5_d1", 7'h0E, 4'hD, 1'b0, 0, 16'h0, 4'h0);
        check_slot("f5_d2", 7'h7F, 4'hB, 1'b0, 0, 16'h0, 4'h0);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("f5_d3_seg", 16'(seg), 16'h000E);
            chk("f5_d3_an",  16'(an),  16'h0007);
        end
        reset = 1'b1;
        step();
        chk("midrst_seg",   16'(seg),   16'h007F);
        chk("midrst_an",    16'(an),    16'h000F);
        chk("midrst_frame", 16'(frame), 16'h0);

        reset = 1'b0;
        step();
        chk("re_e1_seg", 16'(seg), 16'h007F);
        chk("re_e1_an",  16'(an),  16'h000F);
        check_slot("r_d0", 7'h40, 4'hE, 1'b0, 0, 16'h0, 4'h0);
        check_slot("r_d1", 7'h40, 4'hD, 1'b0, 0, 16'h0, 4'h0);
        check_slot("r_d2", 7'h40, 4'hB, 1'b0, 0, 16'h0, 4'h0);
        check_slot("r_d3", 7'h40, 4'h7, 1'b1, 0, 16'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
